// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  localparam int unsigned SUB_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } sub_state_e;

  // Counter must reach WIDTH-1 without wrapping, with headroom up to WIDTH.
  function automatic int unsigned sub_cnt_w(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/full_sub_cell.sv
// Combinational 1-bit full subtractor: d = x - y - bi, bo = borrow out.
module full_sub_cell (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  assign d  = x ^ y ^ bi;
  assign bo = (~x & y) | (~(x ^ y) & bi);

endmodule

// File: rtl/serial_sub8.sv
// Bit-serial subtractor a - b - bin, LSB first, behind a start/done handshake.
// Define SERIAL_SUB_OVF_EN to add the signed-overflow output ovf.
module serial_sub8
  import serial_sub_pkg::*;
#(
  parameter int unsigned WIDTH = SUB_WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int unsigned CW = sub_cnt_w(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  sub_state_e       state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] wrk_q, wrk_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             brw_q, brw_d;
  logic             bout_q, bout_d;
  logic             cell_d, cell_bo;
  logic             capture;
  logic             last_bit;

`ifdef SERIAL_SUB_OVF_EN
  logic a_msb_q, a_msb_d;
  logic b_msb_q, b_msb_d;
  logic ovf_q, ovf_d;
`endif

  full_sub_cell u_cell (
    .x  (a_sh_q[0]),
    .y  (b_sh_q[0]),
    .bi (brw_q),
    .d  (cell_d),
    .bo (cell_bo)
  );

  assign capture  = start && (state_q == IDLE || state_q == DONE);
  assign last_bit = (state_q == SHIFT) && (cnt_q == LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (cnt_q == LAST) state_d = DONE;
      DONE:    state_d = start ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    unique case (state_q)
      SHIFT:   busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath next values
  always_comb begin
    a_sh_d = a_sh_q;
    b_sh_d = b_sh_q;
    wrk_d  = wrk_q;
    brw_d  = brw_q;
    cnt_d  = cnt_q;
    diff_d = diff_q;
    bout_d = bout_q;
`ifdef SERIAL_SUB_OVF_EN
    a_msb_d = a_msb_q;
    b_msb_d = b_msb_q;
    ovf_d   = ovf_q;
`endif
    if (capture) begin
      a_sh_d = a;
      b_sh_d = b;
      brw_d  = bin;
      cnt_d  = '0;
`ifdef SERIAL_SUB_OVF_EN
      a_msb_d = a[WIDTH-1];
      b_msb_d = b[WIDTH-1];
`endif
    end else if (state_q == SHIFT) begin
      a_sh_d = a_sh_q >> 1;
      b_sh_d = b_sh_q >> 1;
      wrk_d  = {cell_d, wrk_q[WIDTH-1:1]};
      brw_d  = cell_bo;
      cnt_d  = cnt_q + CW'(1);
    end
    // Result registers move only on the edge that enters DONE.
    if (last_bit) begin
      diff_d = {cell_d, wrk_q[WIDTH-1:1]};
      bout_d = cell_bo;
`ifdef SERIAL_SUB_OVF_EN
      ovf_d  = (a_msb_q != b_msb_q) && (cell_d != a_msb_q);
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh_q <= '0;
      b_sh_q <= '0;
      wrk_q  <= '0;
      brw_q  <= 1'b0;
      cnt_q  <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
    end else begin
      a_sh_q <= a_sh_d;
      b_sh_q <= b_sh_d;
      wrk_q  <= wrk_d;
      brw_q  <= brw_d;
      cnt_q  <= cnt_d;
      diff_q <= diff_d;
      bout_q <= bout_d;
    end
  end

`ifdef SERIAL_SUB_OVF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_msb_q <= 1'b0;
      b_msb_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_msb_q <= a_msb_d;
      b_msb_q <= b_msb_d;
      ovf_q   <= ovf_d;
    end
  end

  assign ovf = ovf_q;
`endif

  assign diff = diff_q;
  assign bout = bout_q;

endmodule

// File: tb/tb_serial_sub8.sv
// Scoreboard bench for serial_sub8: expected results queued at start, compared at done.
module tb_serial_sub8;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         bin = 1'b0;
  logic         busy, done, bout;
  logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
  logic         ovf;
`endif

  exp_t         sb[$];
  exp_t         e;
  logic [W-1:0] held;
  int           checks = 0;
  int           failures = 0;
  int           cyc;

  always #5 clk = ~clk;

  serial_sub8 #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .diff  (diff),
    .bout  (bout)
`ifdef SERIAL_SUB_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
    exp_t       r;
    logic [W:0] t;
    t      = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
    r.diff = t[W-1:0];
    r.bout = t[W];
    r.ovf  = (x[W-1] != y[W-1]) && (t[W-1] != x[W-1]);
    return r;
  endfunction

  // Pulse start for one edge and queue the expected result; returns at the
  // negedge right after the capture edge.
  task automatic start_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi, input bit push);
    @(negedge clk);
    a = x; b = y; bin = bi; start = 1'b1;
    if (push) sb.push_back(model(x, y, bi));
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      failures++;
      $display("FAIL reset_state got busy=%b done=%b diff=%h bout=%b exp 0/0/00/0", busy, done, diff, bout);
    end
    rst_n = 1'b1;
    held = 8'h00;
  endtask

  task automatic test_basic();
    start_op(8'h05, 8'h03, 1'b0, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      checks++;
      if (busy !== 1'b1) begin failures++; $display("FAIL basic_busy cyc=%0d got=%b exp=1", cyc, busy); end
      @(negedge clk); cyc++;
    end
    checks++;
    if (cyc != 9) begin failures++; $display("FAIL basic_latency got=%0d exp=9", cyc); end
    e = sb.pop_front();
    checks++;
    if (diff !== e.diff || bout !== e.bout || diff !== 8'h02 || busy !== 1'b0) begin
      failures++;
      $display("FAIL basic_result got diff=%h bout=%b busy=%b exp diff=%h bout=%b busy=0", diff, bout, busy, e.diff, e.bout);
    end
    held = e.diff;
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL basic_done_pulse got=%b exp=0", done); end
  endtask

  task automatic test_borrow_edges();
    logic [W-1:0] ta [3] = '{8'h00, 8'hFF, 8'h00};
    logic [W-1:0] tb [3] = '{8'h01, 8'h00, 8'hFF};
    logic         tbi[3] = '{1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], tbi[i], 1);
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      checks++;
      if (cyc != 9 || diff !== e.diff || bout !== e.bout) begin
        failures++;
        $display("FAIL borrow_edge[%0d] got cyc=%0d diff=%h bout=%b exp cyc=9 diff=%h bout=%b", i, cyc, diff, bout, e.diff, e.bout);
      end
      held = e.diff;
      @(negedge clk);
      checks++;
      if (done !== 1'b0) begin failures++; $display("FAIL borrow_edge_pulse[%0d] got=%b exp=0", i, done); end
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    a = 8'h91; b = 8'h90; bin = 1'b1; start = 1'b1;
    sb.push_back(model(8'h91, 8'h90, 1'b1));
    @(negedge clk);
    a = 8'h25; b = 8'h22; bin = 1'b1;
    sb.push_back(model(8'h25, 8'h22, 1'b1));
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    checks++;
    if (cyc != 9 || diff !== e.diff || bout !== e.bout) begin
      failures++;
      $display("FAIL b2b_first got cyc=%0d diff=%h bout=%b exp cyc=9 diff=%h bout=%b", cyc, diff, bout, e.diff, e.bout);
    end
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    checks++;
    if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart busy got=%b exp=1", busy); end
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    checks++;
    if (cyc != 9 || diff !== e.diff || bout !== e.bout || diff !== 8'h02) begin
      failures++;
      $display("FAIL b2b_second got gap=%0d diff=%h bout=%b exp gap=9 diff=%h bout=%b", cyc, diff, bout, e.diff, e.bout);
    end
    held = e.diff;
  endtask

  task automatic test_start_ignored();
    start_op(8'h18, 8'h30, 1'b0, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin
      checks++;
      if (diff !== held) begin failures++; $display("FAIL hold_diff cyc=%0d got=%h exp=%h", cyc, diff, held); end
      if (cyc == 3) begin a = 8'hAA; b = 8'h01; start = 1'b1; end
      if (cyc == 4) begin a = 8'h3C; b = 8'hC3; bin = 1'b1; start = 1'b0; end
      @(negedge clk); cyc++;
    end
    e = sb.pop_front();
    checks++;
    if (cyc != 9 || diff !== e.diff || bout !== e.bout) begin
      failures++;
      $display("FAIL ignore_start got cyc=%0d diff=%h bout=%b exp cyc=9 diff=%h bout=%b", cyc, diff, bout, e.diff, e.bout);
    end
    held = e.diff;
    cyc = 0;
    repeat (12) begin @(negedge clk); if (done === 1'b1) cyc++; end
    checks++;
    if (cyc != 0) begin failures++; $display("FAIL ignore_extra_done got=%0d exp=0", cyc); end
  endtask

  task automatic test_reset_mid();
    start_op(8'h5A, 8'h11, 1'b0, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0 || diff !== 8'h00 || bout !== 1'b0) begin
      failures++;
      $display("FAIL midreset_outputs got busy=%b done=%b diff=%h bout=%b exp 0/0/00/0", busy, done, diff, bout);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc = 0;
    repeat (12) begin @(negedge clk); if (done === 1'b1 || busy === 1'b1) cyc++; end
    checks++;
    if (cyc != 0) begin failures++; $display("FAIL midreset_activity got=%0d exp=0", cyc); end
    start_op(8'h01, 8'h01, 1'b1, 1);
    cyc = 1;
    while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
    e = sb.pop_front();
    checks++;
    if (cyc != 9 || diff !== e.diff || bout !== e.bout) begin
      failures++;
      $display("FAIL midreset_after got cyc=%0d diff=%h bout=%b exp cyc=9 diff=%h bout=%b", cyc, diff, bout, e.diff, e.bout);
    end
    held = e.diff;
  endtask

`ifdef SERIAL_SUB_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] ta [3] = '{8'h80, 8'h7F, 8'h05};
    logic [W-1:0] tb [3] = '{8'h01, 8'hFF, 8'h03};
    for (int i = 0; i < 3; i++) begin
      start_op(ta[i], tb[i], 1'b0, 1);
      cyc = 1;
      while (done !== 1'b1 && cyc < 40) begin @(negedge clk); cyc++; end
      e = sb.pop_front();
      checks++;
      if (cyc != 9 || diff !== e.diff || bout !== e.bout || ovf !== e.ovf) begin
        failures++;
        $display("FAIL ovf[%0d] got cyc=%0d diff=%h bout=%b ovf=%b exp cyc=9 diff=%h bout=%b ovf=%b",
                 i, cyc, diff, bout, ovf, e.diff, e.bout, e.ovf);
      end
      held = e.diff;
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_borrow_edges();
    test_back_to_back();
    test_start_ignored();
    test_reset_mid();
`ifdef SERIAL_SUB_OVF_EN
    test_ovf();
`endif
    checks++;
    if (sb.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size()); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
